// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                           |
// | Description : Shares one single-port RAM between an instruction-fetch    |
// |               port (i_*) and a load/store port (d_*). At most one access |
// |               is in flight; the response is returned MEM_LATENCY cycles  |
// |               after the grant to the port that owned the access.         |
// |                                                                          |
// | Parameters  : AW           address width                                 |
// |               DW           data width (byte mask width is DW/8)          |
// |               MEM_LATENCY  RAM read latency in cycles (>= 1)             |
// |                                                                          |
// | Ports       : clk_i, rst_ni        clock / async active-low reset        |
// |               i_req_i, i_addr_i    fetch request                         |
// |               i_gnt_o              fetch accepted (combinational)        |
// |               i_rvalid_o/i_rdata_o fetch response pulse                  |
// |               d_req_i, d_we_i, d_wmask_i, d_addr_i, d_wdata_i            |
// |                                    load/store request                    |
// |               d_gnt_o              load/store accepted (combinational)   |
// |               d_rvalid_o/d_rdata_o load data / store ack (data 0)        |
// |               mem_req_o, mem_we_o, mem_wmask_o, mem_addr_o, mem_wdata_o  |
// |                                    RAM strobe and fields                 |
// |               mem_rdata_i          RAM read data                         |
// |                                                                          |
// | Config      : RR_ARB_EN  defined   -> round-robin between the two ports  |
// |                          undefined -> fixed priority, data over fetch    |
// |                                                                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   // fetch port
   input  logic            i_req_i,
   input  logic [AW-1:0]   i_addr_i,
   output logic            i_gnt_o,
   output logic            i_rvalid_o,
   output logic [DW-1:0]   i_rdata_o,
   // load/store port
   input  logic            d_req_i,
   input  logic            d_we_i,
   input  logic [DW/8-1:0] d_wmask_i,
   input  logic [AW-1:0]   d_addr_i,
   input  logic [DW-1:0]   d_wdata_i,
   output logic            d_gnt_o,
   output logic            d_rvalid_o,
   output logic [DW-1:0]   d_rdata_o,
   // memory port
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [DW/8-1:0] mem_wmask_o,
   output logic [AW-1:0]   mem_addr_o,
   output logic [DW-1:0]   mem_wdata_o,
   input  logic [DW-1:0]   mem_rdata_i
);

   // The counter only has to hold MEM_LATENCY-1 down to 0.
   localparam int                 c_cnt_w    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(MEM_LATENCY - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   generate
      if (MEM_LATENCY < 1) begin : g_bad_latency
         $error("mem_port_arbiter: MEM_LATENCY must be >= 1");
      end
   endgenerate

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_cnt_w-1:0] r_cnt;
   logic [c_cnt_w-1:0] w_cnt_nxt;
   logic               r_owner_d;       // 1: data port owns the access in flight
   logic               w_owner_d_nxt;
   logic               r_owner_store;   // access in flight is a store -> ack data 0
   logic               w_owner_store_nxt;

   logic               w_grant;         // an access is issued this cycle
   logic               w_sel_d;         // data port wins when a grant is issued

   // Grants are suppressed while reset is asserted so every output is 0
   // during reset even if a requester keeps its request high.
   assign w_grant = rst_ni && (r_state == ST_IDLE) && (i_req_i || d_req_i);

`ifdef RR_ARB_EN
   // Remembers which port was granted last; starts at fetch so the first
   // conflict goes to the data port.
   logic r_last_gnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_last_gnt_d <= 1'b0;
      end else if (w_grant) begin
         r_last_gnt_d <= w_sel_d;
      end
   end

   assign w_sel_d = d_req_i && (!i_req_i || !r_last_gnt_d);
`else
   assign w_sel_d = d_req_i;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_owner_d     <= 1'b0;
         r_owner_store <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_owner_d     <= w_owner_d_nxt;
         r_owner_store <= w_owner_store_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_cnt;
      w_owner_d_nxt     = r_owner_d;
      w_owner_store_nxt = r_owner_store;
      i_gnt_o           = 1'b0;
      d_gnt_o           = 1'b0;
      i_rvalid_o        = 1'b0;
      d_rvalid_o        = 1'b0;
      i_rdata_o         = '0;
      d_rdata_o         = '0;
      mem_req_o         = 1'b0;
      mem_we_o          = 1'b0;
      mem_wmask_o       = '0;
      mem_addr_o        = '0;
      mem_wdata_o       = '0;

      case (r_state)
         ST_IDLE: begin
            if (w_grant) begin
               mem_req_o   = 1'b1;
               w_state_nxt = ST_WAIT;
               w_cnt_nxt   = c_cnt_init;
               w_owner_d_nxt = w_sel_d;
               if (w_sel_d) begin
                  d_gnt_o           = 1'b1;
                  mem_we_o          = d_we_i;
                  mem_wmask_o       = d_wmask_i;
                  mem_addr_o        = d_addr_i;
                  mem_wdata_o       = d_wdata_i;
                  w_owner_store_nxt = d_we_i;
               end else begin
                  i_gnt_o           = 1'b1;
                  mem_addr_o        = i_addr_i;
                  w_owner_store_nxt = 1'b0;
               end
            end
         end

         ST_WAIT: begin
            if (r_cnt == '0) begin
               // Response cycle: no new grant here, back to IDLE next cycle.
               w_state_nxt = ST_IDLE;
               if (r_owner_d) begin
                  d_rvalid_o = 1'b1;
                  d_rdata_o  = r_owner_store ? '0 : mem_rdata_i;
               end else begin
                  i_rvalid_o = 1'b1;
                  i_rdata_o  = mem_rdata_i;
               end
            end else begin
               w_cnt_nxt = r_cnt - c_cnt_one;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_port_arbiter                                        |
// | Description : Self-checking bench for mem_port_arbiter with a 16-word    |
// |               RAM model, a vector table and a response scoreboard.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

   localparam int L = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt_o, i_rvalid_o;
   logic [31:0] i_rdata_o;
   logic        d_req, d_we;
   logic [3:0]  d_mask;
   logic [31:0] d_addr, d_wdata;
   logic        d_gnt_o, d_rvalid_o;
   logic [31:0] d_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_wmask_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [31:0] mem_rdata_i;

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(L)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .i_req_i     (i_req),
      .i_addr_i    (i_addr),
      .i_gnt_o     (i_gnt_o),
      .i_rvalid_o  (i_rvalid_o),
      .i_rdata_o   (i_rdata_o),
      .d_req_i     (d_req),
      .d_we_i      (d_we),
      .d_wmask_i   (d_mask),
      .d_addr_i    (d_addr),
      .d_wdata_i   (d_wdata),
      .d_gnt_o     (d_gnt_o),
      .d_rvalid_o  (d_rvalid_o),
      .d_rdata_o   (d_rdata_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_wmask_o (mem_wmask_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- RAM model ----------------
   logic        mem_init;
   logic [31:0] mem [0:15];
   logic [31:0] rd_pipe [0:L-1];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int k = 0; k < 16; k++) mem[k] <= 32'hC0DE_0000 | k;
         mem[2] <= 32'h0050_0093;
         mem[4] <= 32'h1122_3344;
      end else if (mem_req_o && mem_we_o) begin
         for (int b = 0; b < 4; b++)
            if (mem_wmask_o[b]) mem[mem_addr_o[5:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
      rd_pipe[0] <= mem_req_o ? mem[mem_addr_o[5:2]] : 32'hBAD0_0BAD;
      for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign mem_rdata_i = rd_pipe[L-1];

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        is_d;
      logic [31:0] rdata;
      int          due;
   } sb_t;
   sb_t sb[$];

   always @(negedge clk) begin
      sb_t e;
      if (rst_n) begin
         if (i_rvalid_o && d_rvalid_o) check("both_rvalid", 1, 0);
         if (i_rvalid_o || d_rvalid_o) begin
            if (sb.size() == 0) begin
               check("unexpected_rvalid", 1, 0);
            end else begin
               e = sb.pop_front();
               check("rvalid_port", d_rvalid_o, e.is_d);
               check("rdata", d_rvalid_o ? d_rdata_o : i_rdata_o, e.rdata);
               check("rvalid_cycle", cyc, e.due);
            end
         end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            check("missing_rvalid", 0, 1);
            void'(sb.pop_front());
         end
         if (!i_rvalid_o) check("i_rdata_idle", i_rdata_o, 0);
         if (!d_rvalid_o) check("d_rdata_idle", d_rdata_o, 0);
      end
   end

   task automatic wait_grant(output logic got);
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (i_gnt_o || d_gnt_o) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check("grant_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int k = 0; k < 20; k++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      if (sb.size() != 0) begin
         check("drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   typedef struct {
      logic        d_req;
      logic        d_we;
      logic [3:0]  d_mask;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic        i_req;
      logic [31:0] i_addr;
      logic        exp_d;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [11];

   initial begin
      logic got;
      logic exp_d;
      logic last_d;
      int   prev_g;

      vecs[0]  = '{1'b0, 1'b0, 4'h0, 32'h00, 32'h0,         1'b1, 32'h08, 1'b0, 32'h0050_0093};
      vecs[1]  = '{1'b1, 1'b1, 4'h3, 32'h10, 32'hDEAD_BEEF, 1'b1, 32'h04, 1'b1, 32'h0};
      vecs[2]  = '{1'b1, 1'b0, 4'h0, 32'h10, 32'h0,         1'b0, 32'h00, 1'b1, 32'h1122_BEEF};
      vecs[3]  = '{1'b0, 1'b0, 4'h0, 32'h00, 32'h0,         1'b1, 32'h04, 1'b0, 32'hC0DE_0001};
      vecs[4]  = '{1'b1, 1'b1, 4'h0, 32'h14, 32'hFFFF_FFFF, 1'b0, 32'h00, 1'b1, 32'h0};
      vecs[5]  = '{1'b1, 1'b0, 4'h0, 32'h14, 32'h0,         1'b0, 32'h00, 1'b1, 32'hC0DE_0005};
      vecs[6]  = '{1'b1, 1'b1, 4'hC, 32'h18, 32'hAABB_CCDD, 1'b0, 32'h00, 1'b1, 32'h0};
      vecs[7]  = '{1'b0, 1'b0, 4'h0, 32'h00, 32'h0,         1'b1, 32'h1A, 1'b0, 32'hAABB_0006};
      vecs[8]  = '{1'b1, 1'b1, 4'hF, 32'h1C, 32'h1234_5678, 1'b1, 32'h00, 1'b1, 32'h0};
      vecs[9]  = '{1'b1, 1'b0, 4'h0, 32'h1C, 32'h0,         1'b0, 32'h00, 1'b1, 32'h1234_5678};
      vecs[10] = '{1'b0, 1'b0, 4'h0, 32'h00, 32'h0,         1'b1, 32'h3C, 1'b0, 32'hC0DE_000F};

      rst_n = 1'b0; mem_init = 1'b1;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_mask = '0; d_addr = '0; d_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_req", mem_req_o, 0);
      check("rst_gnt", {i_gnt_o, d_gnt_o}, 0);
      check("rst_rvalid", {i_rvalid_o, d_rvalid_o}, 0);
      mem_init = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      check("idle_mem_req", mem_req_o, 0);
      check("idle_mem_addr", mem_addr_o, 0);

      // ---------------- vector table ----------------
      for (int v = 0; v < 11; v++) begin
         @(posedge clk); #1;
         d_req = vecs[v].d_req; d_we = vecs[v].d_we; d_mask = vecs[v].d_mask;
         d_addr = vecs[v].d_addr; d_wdata = vecs[v].d_wdata;
         i_req = vecs[v].i_req; i_addr = vecs[v].i_addr;
         wait_grant(got);
         if (got) begin
            check($sformatf("v%0d_d_gnt", v), d_gnt_o, vecs[v].exp_d);
            check($sformatf("v%0d_i_gnt", v), i_gnt_o, !vecs[v].exp_d);
            check($sformatf("v%0d_mem_req", v), mem_req_o, 1);
            check($sformatf("v%0d_mem_addr", v), mem_addr_o,
                  vecs[v].exp_d ? vecs[v].d_addr : vecs[v].i_addr);
            check($sformatf("v%0d_mem_we", v), mem_we_o, vecs[v].exp_d & vecs[v].d_we);
            check($sformatf("v%0d_mem_wmask", v), mem_wmask_o,
                  vecs[v].exp_d ? vecs[v].d_mask : 4'h0);
            check($sformatf("v%0d_mem_wdata", v), mem_wdata_o,
                  vecs[v].exp_d ? vecs[v].d_wdata : 32'h0);
            sb.push_back('{is_d: vecs[v].exp_d, rdata: vecs[v].exp_rdata, due: cyc + L});
         end
         @(posedge clk); #1;
         d_req = 1'b0; i_req = 1'b0;
         drain();
         @(negedge clk);
         check($sformatf("v%0d_bus_idle", v), mem_req_o, 0);
      end
      check("word4_masked_store", mem[4], 32'h1122_BEEF);
      check("word5_zero_mask", mem[5], 32'hC0DE_0005);
      check("word6_upper_store", mem[6], 32'hAABB_0006);

      // ---------------- both ports held: order and spacing ----------------
      last_d = 1'b0;   // last table grant was a fetch
      prev_g = 0;
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b0; d_mask = '0; d_addr = 32'h10; d_wdata = '0;
      i_req = 1'b1; i_addr = 32'h08;
      for (int n = 0; n < 4; n++) begin
         wait_grant(got);
         if (got) begin
`ifdef RR_ARB_EN
            exp_d = !last_d;
`else
            exp_d = 1'b1;
`endif
            check($sformatf("held%0d_d_gnt", n), d_gnt_o, exp_d);
            check($sformatf("held%0d_i_gnt", n), i_gnt_o, !exp_d);
            if (n > 0) check($sformatf("held%0d_spacing", n), cyc - prev_g, L + 1);
            prev_g = cyc;
            last_d = exp_d;
            sb.push_back('{is_d: exp_d, rdata: exp_d ? 32'h1122_BEEF : 32'h0050_0093,
                           due: cyc + L});
         end
      end
      @(posedge clk); #1;
      d_req = 1'b0; i_req = 1'b0;
      drain();

      // ---------------- data request raised and dropped during WAIT ----------------
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 32'h08;
      wait_grant(got);
      if (got) begin
         check("drop_i_gnt", i_gnt_o, 1);
         sb.push_back('{is_d: 1'b0, rdata: 32'h0050_0093, due: cyc + L});
      end
      @(posedge clk); #1;
      i_req = 1'b0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      @(negedge clk);
      check("drop_no_dgnt", d_gnt_o, 0);
      check("drop_no_memreq", mem_req_o, 0);
      @(posedge clk); #1;
      d_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("drop_idle%0d", k), {mem_req_o, d_gnt_o, i_gnt_o}, 0);
      end
      drain();

      // ---------------- reset during WAIT of a fetch ----------------
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 32'h08;
      wait_grant(got);
      if (got) check("rstw_i_gnt", i_gnt_o, 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("rstw_outputs", {i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o, mem_req_o, mem_we_o}, 0);
      check("rstw_mem_addr", mem_addr_o, 0);
      check("rstw_i_rdata", i_rdata_o, 0);
      @(posedge clk); #1;
      check("rstw_no_rvalid", {i_rvalid_o, i_gnt_o, mem_req_o}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rstw_regrant", i_gnt_o, 1);
      check("rstw_regrant_addr", mem_addr_o, 32'h08);
      if (i_gnt_o) sb.push_back('{is_d: 1'b0, rdata: 32'h0050_0093, due: cyc + L});
      @(posedge clk); #1;
      i_req = 1'b0;
      drain();
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
